// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the debug dump FSM states.
// Pure declarations, no logic.
package cpu_pkg;

  localparam int         NUM_ARCH_REGS = 32;
  localparam logic [4:0] ZERO_REG      = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile.sv
// 32x64 register file: two combinational read ports and one write port (writes land at the clock edge).
// The zero register always reads 0 and ignores writes. There is no backpressure.
module regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [DATA_W-1:0] r_regs [NUM_ARCH_REGS];

  // Storage is left without a reset so that a debug reset does not wipe the architectural state.
  always_ff @(posedge clk) begin
    if (RegWrite && (WriteRegister != ZERO_REG)) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  assign ReadData1 = (ReadRegister1 == ZERO_REG) ? '0 : r_regs[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == ZERO_REG) ? '0 : r_regs[ReadRegister2];

endmodule

// File: rtl/regfile_dump.sv
// Walks the register file read port X0..X(NUM_REGS-1) and streams each value with its index, XORing a checksum.
// Each beat costs 2 cycles (READ then SEND). SEND holds its beat stable while out_ready is low.
module regfile_dump
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_ARCH_REGS,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  dump_state_t       r_state;
  dump_state_t       w_next_state;
  logic [4:0]        r_idx;
  logic [DATA_W-1:0] r_out_data;
  logic [4:0]        r_out_idx;
  logic [DATA_W-1:0] r_checksum;
  logic              w_out_valid;
  logic              w_busy;
  logic              w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = READ;
        end
      end
      READ: begin
        w_busy       = 1'b1;
        w_next_state = SEND;
      end
      SEND: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = (r_idx == LAST_IDX) ? DONE : READ;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // The index stops at the last register, so the next start is what rewinds it to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_checksum <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_idx      <= '0;
            r_checksum <= '0;
          end
        end
        READ: begin
          r_out_data <= rd_data;
          r_out_idx  <= r_idx;
        end
        SEND: begin
          if (out_ready) begin
            r_checksum <= r_checksum ^ r_out_data;
            if (r_idx != LAST_IDX) begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_addr   = r_idx;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign done      = w_done;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump beside a regfile: a scenario table drives full dumps against a beat scoreboard,
// and hand-written sequences cover idle reset and reset in the middle of a dump.
module tb_regfile_dump;

  localparam int NR = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [4:0]    rd_addr;
  logic [4:0]    out_idx;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic [DW-1:0] checksum;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [4:0]    wr_addr = 5'd0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic [4:0]    rd1_addr = 5'd0;
  logic [DW-1:0] rd1_data;

  always #5 clk = ~clk;

  regfile #(.DATA_W(DW)) u_rf (
    .clk          (clk),
    .ReadRegister1(rd1_addr),
    .ReadRegister2(rd_addr),
    .WriteRegister(wr_addr),
    .WriteData    (wr_data),
    .RegWrite     (wr_en),
    .ReadData1    (rd1_data),
    .ReadData2    (rd_data)
  );

  regfile_dump #(.NUM_REGS(NR), .DATA_W(DW)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  typedef struct packed {
    logic [4:0]    idx;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            stall_beat;
    int            stall_len;
    int            restart_beat;
    int            wr_beat;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    int            exp_cycles;
    int            exp_dones;
  } scen_t;

  beat_t         sb[$];
  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_ck = '0;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  int            acc_cnt = 0;
  int            cyc = 0;
  scen_t         tbl [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat scoreboard: every accepted beat must match the front of the expected queue.
  always @(negedge clk) begin
    if (!reset && done) done_cnt++;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("beat_idx", 64'(out_idx), 64'(b.idx));
        chk("beat_data", out_data, b.data);
        exp_ck ^= b.data;
        acc_cnt++;
      end
    end
  end

  task automatic rf_write(input logic [4:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a != 5'd31) model[a] = d;
  endtask

  task automatic push_dump();
    sb.delete();
    for (int i = 0; i < NR; i++) begin
      beat_t b;
      b.idx  = 5'(i);
      b.data = (i == NR - 1) ? '0 : model[i];
      sb.push_back(b);
    end
    exp_ck   = '0;
    done_cnt = 0;
    acc_cnt  = 0;
  endtask

  task automatic run_scen(input scen_t s);
    int t0;
    int st_cnt;
    bit restarted;
    bit written;
    bit seen_done;
    push_dump();
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("valid_after_start", 64'(out_valid), 64'd0);
    st_cnt    = 0;
    restarted = 1'b0;
    written   = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 500 && !seen_done; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (cyc - t0 == 1) chk("first_valid", 64'(out_valid), 64'd1);
      if (done) begin
        seen_done = 1'b1;
        chk("done_latency", 64'(cyc - t0), 64'(s.exp_cycles));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("valid_at_done", 64'(out_valid), 64'd0);
        chk("checksum_final", checksum, exp_ck);
      end else if (out_valid) begin
        if (int'(out_idx) == s.stall_beat && st_cnt < s.stall_len) begin
          out_ready = 1'b0;
          st_cnt++;
          chk("stall_data", out_data, sb[0].data);
          chk("stall_idx", 64'(out_idx), 64'(sb[0].idx));
          chk("stall_checksum", checksum, exp_ck);
        end else begin
          out_ready = 1'b1;
        end
        if (int'(out_idx) == s.restart_beat && !restarted) begin
          start     = 1'b1;
          restarted = 1'b1;
        end
        if (int'(out_idx) == s.wr_beat && !written) begin
          wr_en   = 1'b1;
          wr_addr = s.wr_addr;
          wr_data = s.wr_data;
          written = 1'b1;
          if (s.wr_addr != 5'd31) begin
            model[s.wr_addr] = s.wr_data;
            for (int k = 0; k < sb.size(); k++) begin
              beat_t t;
              t = sb[k];
              if (t.idx == s.wr_addr) begin
                t.data = s.wr_data;
                sb[k]  = t;
              end
            end
          end
        end
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 500 cycles");
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'(s.exp_dones));
    chk("beat_count", 64'(acc_cnt), 64'(NR));
    chk("checksum_stable", checksum, exp_ck);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    //          stall  len  restart  wr  wr_addr  wr_data       cycles dones
    tbl[0] = '{-1,    0,   -1,      -1, 5'd0,    64'h0,        64,    1};
    tbl[1] = '{3,     5,   -1,      -1, 5'd0,    64'h0,        69,    1};
    tbl[2] = '{-1,    0,   10,      -1, 5'd0,    64'h0,        64,    1};
    tbl[3] = '{-1,    0,   -1,      5,  5'd20,   64'h1234,     64,    1};

    for (int i = 0; i < NR; i++) model[i] = '0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_checksum", checksum, 64'd0);
      chk("rst_data", out_data, 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    end

    for (int i = 0; i < NR - 1; i++) rf_write(5'(i), 64'hAAAA000000000000 + 64'(i));
    rf_write(5'd31, 64'hDEAD);

    for (int t = 0; t < 4; t++) begin
      run_scen(tbl[t]);
      repeat (3) @(posedge clk);
      #1;
    end

    // Reset while beat 7 is being offered: dump is abandoned with no done pulse.
    push_dump();
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_idx == 5'd7) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL beat7_timeout: got no beat 7 expected beat 7 within 200 cycles");
    end
    reset     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_checksum", checksum, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_idx", 64'(out_idx), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_idle_valid", 64'(out_valid), 64'd0);

    run_scen(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the 32x64 register file. On a start pulse it walks the register file's read port from X0 to X31, captures each 64-bit value, and streams it out as an indexed word over a valid/ready handshake, accumulating an XOR checksum. It sits beside the CPU's register file, sharing ReadRegister2/ReadData2 through a debug mux, and feeds the test/debug host interface.

## Interface

Parameters:
- NUM_REGS, 32: registers walked, X0..X(NUM_REGS-1).
- DATA_W, 64: register and output word width.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a dump; sampled only in IDLE.
- rd_addr  out  5  drives the register file read address.
- rd_data  in  DATA_W  register file read data, combinational from rd_addr.
- out_data  out  DATA_W  captured register value.
- out_idx  out  5  register number of out_data.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts the beat when out_valid and out_ready are high at a clock edge.
- busy  out  1  high in READ and SEND.
- done  out  1  one-cycle pulse after the last beat is accepted.
- checksum  out  DATA_W  XOR of all accepted out_data since the last start.

## Operation

- FSM states: IDLE, READ, SEND, DONE.
- IDLE: start=1 moves to READ, sets idx=0, and clears checksum. start=0 stays in IDLE.
- READ: rd_addr=idx. At the edge, out_data<=rd_data and out_idx<=idx, then move to SEND.
- SEND: out_valid=1, rd_addr holds idx.
  - out_ready=0: stay in SEND. out_data and out_idx hold stable.
  - out_ready=1: checksum<=checksum^out_data. If idx==NUM_REGS-1, go to DONE. Otherwise idx<=idx+1 and go to READ.
- DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- start is ignored in READ, SEND and DONE. It is not queued.
- Register 31 is read like any other. The register file returns 0 for it, so the final beat carries out_data=0.
- The block never writes the register file. Register file writes during a dump are permitted; each beat reflects the value present in its READ cycle.
- idx counter width: 5 bits. It never increments past NUM_REGS-1, so there is no wrap.

## Timing

- Reset values: state=IDLE, idx=0, rd_addr=0, out_data=0, out_idx=0, out_valid=0, busy=0, done=0, checksum=0.
- Reset asserted in any state returns to IDLE at the next edge and abandons any partial dump. There is no done pulse, and checksum is cleared.
- start high at edge N gives busy=1 and READ state in cycle N+1. The first out_valid appears in cycle N+2.
- With out_ready held high, each beat costs 2 cycles.
  - The last beat is accepted at edge N+2*NUM_REGS.
  - done is high in the following cycle.
  - busy falls in the same cycle done rises.
- checksum updates at the acceptance edge. It is final and stable from the done cycle until the next start.
- out_valid, out_data, out_idx, busy and done are all registered or decoded from the state register. No input reaches an output combinationally, except rd_data into the captured register.
- start held high across the DONE cycle starts a new dump from IDLE one cycle later.

## Structure

- Shared package (cpu_pkg): the state enum typedef dump_state_t {IDLE, READ, SEND, DONE}, and the constants NUM_ARCH_REGS=32 and ZERO_REG=5'd31.
- Single flat module. The index counter and XOR accumulator are too small to justify sub-modules.
- The bench instantiates regfile plus regfile_dump, with rd_addr on ReadRegister2 and ReadData2 on rd_data.

## Test plan

- Reset idle: hold reset for 2 cycles, then release with start=0 for 10 cycles. Required: all outputs stay at reset values and rd_addr=0.
- Full dump with ready always high:
  - Stimulus: preload Xi=64'hAAAA000000000000+i for i=0..30, then pulse start.
  - Required: 32 beats with out_idx 0..31 and matching data, and beat 31 carries 0.
  - Required: done occurs exactly 64 cycles after the start edge, and checksum equals the XOR of the 31 preload values.
- Backpressure: out_ready=0 for 5 cycles on beat 3. Required: out_valid stays high, out_data=64'hAAAA000000000003 and out_idx=3 hold, and checksum is unchanged until acceptance.
- Start while busy: pulse start again during beat 10. Required: no restart, beats continue 11..31, and exactly one done.
- Reset mid-dump: assert reset during SEND of beat 7. Required: IDLE next cycle, out_valid=0, checksum=0, no done. A new start then dumps from out_idx=0.
- Write during dump: write X20=64'h1234 while beat 5 is pending. Required: beat 20 carries 64'h1234.
